// File: rtl/hpdcache_regbank_arb.sv
// ----------------------------------------------------------------------------
// hpdcache_regbank_arb
//
// Arbitration and sequencing front-end for a single-port (1RW) masked-write
// register bank. A write requester and a read requester share the bank port.
// When both are valid in the same cycle, round-robin priority decides the
// winner. Read data returns exactly one cycle after the read grant.
//
// Optional feature (macro HPDCACHE_REGBANK_ARB_INIT_EN):
//   defined   : after reset the whole bank is swept to zero (DEPTH cycles,
//               busy_o high) before any request is granted.
//   undefined : no sweep; traffic is accepted directly out of reset and
//               busy_o is tied low.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_valid_i      write request valid
//   wr_ready_o      write request granted this cycle
//   wr_addr_i       write address
//   wr_data_i       write data
//   wr_mask_i       per-bit write enable
//   rd_valid_i      read request valid
//   rd_ready_o      read request granted this cycle
//   rd_addr_i       read address
//   rd_rsp_valid_o  read data valid (one cycle after the read grant)
//   rd_rsp_data_o   read data (bank_rdata_i passed through)
//   busy_o          init sweep in progress
//   bank_*_o        bank chip select, write enable, address, wdata, wmask
//   bank_rdata_i    bank registered read data
//
// FSM states (only with HPDCACHE_REGBANK_ARB_INIT_EN):
//   INIT | zero-sweep of the bank, requests held off
//   RUN  | normal arbitrated traffic
// ----------------------------------------------------------------------------
module hpdcache_regbank_arb #(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [ADDR_SIZE-1:0] wr_addr_i,
  input  logic [DATA_SIZE-1:0] wr_data_i,
  input  logic [DATA_SIZE-1:0] wr_mask_i,

  input  logic                 rd_valid_i,
  output logic                 rd_ready_o,
  input  logic [ADDR_SIZE-1:0] rd_addr_i,
  output logic                 rd_rsp_valid_o,
  output logic [DATA_SIZE-1:0] rd_rsp_data_o,

  output logic                 busy_o,

  output logic                 bank_cs_o,
  output logic                 bank_we_o,
  output logic [ADDR_SIZE-1:0] bank_addr_o,
  output logic [DATA_SIZE-1:0] bank_wdata_o,
  output logic [DATA_SIZE-1:0] bank_wmask_o,
  input  logic [DATA_SIZE-1:0] bank_rdata_i
);

  // rr_prio names the side that wins the next contended cycle.
  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } prio_e;

  prio_e                rr_prio_q, rr_prio_d;
  logic                 rsp_valid_q;
  logic                 wr_gnt, rd_gnt;
  logic                 in_init;
  logic [ADDR_SIZE-1:0] init_addr;

`ifdef HPDCACHE_REGBANK_ARB_INIT_EN
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      // The last sweep write is issued this cycle; leave with the counter
      // parked at zero so a later sweep always starts clean.
      if (init_cnt_q == ADDR_SIZE'(DEPTH - 1)) begin
        state_d    = RUN;
        init_cnt_d = '0;
      end
    end
  end

  assign in_init   = (state_q == INIT);
  assign init_addr = init_cnt_q;
`else
  assign in_init   = 1'b0;
  assign init_addr = '0;
`endif

  // Grant is purely combinational from the valids; priority flips to the
  // loser only when both sides actually contend.
  always_comb begin
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    rr_prio_d = rr_prio_q;
    if (!in_init) begin
      if (wr_valid_i && rd_valid_i) begin
        if (rr_prio_q == PRIO_RD) begin
          rd_gnt    = 1'b1;
          rr_prio_d = PRIO_WR;
        end else begin
          wr_gnt    = 1'b1;
          rr_prio_d = PRIO_RD;
        end
      end else begin
        wr_gnt = wr_valid_i;
        rd_gnt = rd_valid_i;
      end
    end
  end

  // Bank port mux; every field is zero when the bank is not selected.
  always_comb begin
    bank_cs_o    = 1'b0;
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_wmask_o = '0;
    if (in_init) begin
      bank_cs_o    = 1'b1;
      bank_we_o    = 1'b1;
      bank_addr_o  = init_addr;
      bank_wmask_o = '1;
    end else if (wr_gnt) begin
      bank_cs_o    = 1'b1;
      bank_we_o    = 1'b1;
      bank_addr_o  = wr_addr_i;
      bank_wdata_o = wr_data_i;
      bank_wmask_o = wr_mask_i;
    end else if (rd_gnt) begin
      bank_cs_o    = 1'b1;
      bank_addr_o  = rd_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_prio_q   <= PRIO_RD;
      rsp_valid_q <= 1'b0;
    end else begin
      rr_prio_q   <= rr_prio_d;
      rsp_valid_q <= rd_gnt;
    end
  end

  assign wr_ready_o     = wr_gnt;
  assign rd_ready_o     = rd_gnt;
  assign rd_rsp_valid_o = rsp_valid_q;
  // The bank registers its read data, so it lines up with rsp_valid_q.
  assign rd_rsp_data_o  = bank_rdata_i;
  assign busy_o         = in_init;

endmodule

// File: tb/tb_hpdcache_regbank_arb.sv
module tb_hpdcache_regbank_arb;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

`ifdef HPDCACHE_REGBANK_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid_i, wr_ready_o;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i, wr_mask_i;
  logic          rd_valid_i, rd_ready_o;
  logic [AW-1:0] rd_addr_i;
  logic          rd_rsp_valid_o;
  logic [DW-1:0] rd_rsp_data_o;
  logic          busy_o;
  logic          bank_cs_o, bank_we_o;
  logic [AW-1:0] bank_addr_o;
  logic [DW-1:0] bank_wdata_o, bank_wmask_o;
  logic [DW-1:0] bank_rdata_i;

  always #5 clk = ~clk;

  hpdcache_regbank_arb #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .wr_mask_i      (wr_mask_i),
    .rd_valid_i     (rd_valid_i),
    .rd_ready_o     (rd_ready_o),
    .rd_addr_i      (rd_addr_i),
    .rd_rsp_valid_o (rd_rsp_valid_o),
    .rd_rsp_data_o  (rd_rsp_data_o),
    .busy_o         (busy_o),
    .bank_cs_o      (bank_cs_o),
    .bank_we_o      (bank_we_o),
    .bank_addr_o    (bank_addr_o),
    .bank_wdata_o   (bank_wdata_o),
    .bank_wmask_o   (bank_wmask_o),
    .bank_rdata_i   (bank_rdata_i)
  );

  // Bank: 1RW masked-write memory with registered read data. Unwritten
  // entries return a seed-derived pattern so stale contents are visible.
  logic [DW-1:0] seed;
  logic [DW-1:0] bank_mem [DEPTH];
  bit            bank_wr  [DEPTH];

  function automatic logic [DW-1:0] init_pat(input int a, input logic [DW-1:0] s);
    return s ^ (32'h9E37_79B9 * (a + 1));
  endfunction

  always @(posedge clk) begin
    if (bank_cs_o) begin
      if (bank_we_o) begin
        bank_mem[bank_addr_o] <= ((bank_wr[bank_addr_o] ? bank_mem[bank_addr_o]
                                   : init_pat(int'(bank_addr_o), seed)) & ~bank_wmask_o)
                                 | (bank_wdata_o & bank_wmask_o);
        bank_wr[bank_addr_o]  <= 1'b1;
      end else begin
        bank_rdata_i <= bank_wr[bank_addr_o] ? bank_mem[bank_addr_o]
                        : init_pat(int'(bank_addr_o), seed);
      end
    end
  end

  // Reference model: contents as the requesters should see them, whose turn
  // it is on contention, how far the zero sweep has got, and the read
  // answer owed next cycle.
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_prio_rd;
  int            m_sweep;
  bit            m_rsp_pend;
  logic [DW-1:0] m_rsp_data;

  bit            e_wr, e_rd, e_cs, e_we, e_busy, e_rsp_v;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_wmask, e_rsp_d;

  task automatic model_reset();
    m_prio_rd  = 1'b1;
    m_sweep    = INIT_EN ? 0 : DEPTH;
    m_rsp_pend = 1'b0;
  endtask

  task automatic predict();
    e_rsp_v = m_rsp_pend;
    e_rsp_d = m_rsp_data;
    e_wr = 0; e_rd = 0; e_cs = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; e_wmask = '0;
    e_busy = (m_sweep < DEPTH);
    if (e_busy) begin
      e_cs = 1; e_we = 1; e_addr = AW'(m_sweep); e_wmask = '1;
      ref_mem[m_sweep] = '0;
      m_sweep++;
    end else begin
      if (wr_valid_i && rd_valid_i) begin
        e_rd = m_prio_rd;
        e_wr = !m_prio_rd;
        m_prio_rd = !m_prio_rd;
      end else begin
        e_wr = wr_valid_i;
        e_rd = rd_valid_i;
      end
      if (e_wr) begin
        e_cs = 1; e_we = 1; e_addr = wr_addr_i; e_wdata = wr_data_i; e_wmask = wr_mask_i;
        ref_mem[wr_addr_i] = (ref_mem[wr_addr_i] & ~wr_mask_i) | (wr_data_i & wr_mask_i);
      end
      if (e_rd) begin
        e_cs = 1; e_addr = rd_addr_i;
      end
    end
    m_rsp_pend = e_rd;
    if (e_rd) m_rsp_data = ref_mem[rd_addr_i];
  endtask

  // Drive one cycle's inputs (called just after a falling edge), let the
  // combinational outputs settle, then advance the model.
  task automatic drive(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [DW-1:0] wm, input bit rv, input logic [AW-1:0] ra);
    wr_valid_i = wv; wr_addr_i = wa; wr_data_i = wd; wr_mask_i = wm;
    rd_valid_i = rv; rd_addr_i = ra;
    #1;
    predict();
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_valid_i = 0; rd_valid_i = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_sweep();
    for (int i = 0; i < DEPTH && INIT_EN; i++) begin
      drive(0, '0, '0, '0, 0, '0);
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (busy_o !== INIT_EN) begin
      n_fail++; $display("FAIL reset_busy got=%b want=%b", busy_o, INIT_EN);
    end
    n_checks++;
    if (rd_rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", rd_rsp_valid_o);
    end
  endtask

`ifdef HPDCACHE_REGBANK_ARB_INIT_EN
  task automatic test_init_sweep();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, '0, '0, '0, 1, 4'd5);
      n_checks++;
      if ({busy_o, bank_cs_o, bank_we_o, rd_ready_o} !== 4'b1110 || bank_addr_o !== AW'(i)
          || bank_wdata_o !== 32'h0 || bank_wmask_o !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL sweep_cycle%0d busy/cs/we/rdy=%b addr=%0d wdata=%h wmask=%h want 1110 addr=%0d 0 ffffffff",
                 i, {busy_o, bank_cs_o, bank_we_o, rd_ready_o}, bank_addr_o, bank_wdata_o, bank_wmask_o, i);
      end
      tick();
    end
    drive(0, '0, '0, '0, 1, 4'd5);
    n_checks++;
    if (busy_o !== 1'b0 || rd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL sweep_done busy=%b rd_ready=%b want 0 1", busy_o, rd_ready_o);
    end
    tick();
    drive(0, '0, '0, '0, 0, '0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== 32'h0) begin
      n_fail++; $display("FAIL sweep_read5 valid=%b data=%h want 1 00000000", rd_rsp_valid_o, rd_rsp_data_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_init();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(0, '0, '0, '0, 0, '0);
      tick();
    end
    drive(1, 4'd1, 32'h1, 32'h1, 1, 4'd2);
    n_checks++;
    if (bank_addr_o !== 4'd7 || wr_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL midinit_pre addr=%0d wr_ready=%b want 7 0", bank_addr_o, wr_ready_o);
    end
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bank_addr_o !== 4'd0 || busy_o !== 1'b1 || rd_rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL midinit_rst addr=%0d busy=%b rsp=%b want 0 1 0", bank_addr_o, busy_o, rd_rsp_valid_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, '0, '0, '0, 1, 4'd2);
      n_checks++;
      if (busy_o !== 1'b1 || bank_addr_o !== AW'(i) || rd_rsp_valid_o !== 1'b0 || rd_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL midinit_sweep%0d busy=%b addr=%0d rsp=%b rdy=%b want 1 %0d 0 0",
                 i, busy_o, bank_addr_o, rd_rsp_valid_o, rd_ready_o, i);
      end
      tick();
    end
    drive(0, '0, '0, '0, 0, '0);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL midinit_end busy=%b want 0", busy_o);
    end
    tick();
  endtask
`else
  task automatic test_macro_off();
    do_reset();
    drive(0, '0, '0, '0, 1, 4'd9);
    n_checks++;
    if (busy_o !== 1'b0 || rd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL nomacro_first busy=%b rd_ready=%b want 0 1", busy_o, rd_ready_o);
    end
    tick();
    drive(0, '0, '0, '0, 0, '0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== e_rsp_d) begin
      n_fail++; $display("FAIL nomacro_rsp valid=%b data=%h want 1 %h", rd_rsp_valid_o, rd_rsp_data_o, e_rsp_d);
    end
    tick();
  endtask
`endif

  task automatic test_masked_write();
    drive(1, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0);
    n_checks++;
    if (wr_ready_o !== 1'b1 || bank_we_o !== 1'b1 || bank_wdata_o !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mw_first rdy=%b we=%b wdata=%h want 1 1 ffffffff", wr_ready_o, bank_we_o, bank_wdata_o);
    end
    tick();
    drive(1, 4'd3, 32'h1234_5678, 32'h0000_FFFF, 0, '0);
    n_checks++;
    if (bank_addr_o !== 4'd3 || bank_wdata_o !== 32'h1234_5678 || bank_wmask_o !== 32'h0000_FFFF) begin
      n_fail++; $display("FAIL mw_second addr=%0d wdata=%h wmask=%h want 3 12345678 0000ffff",
                         bank_addr_o, bank_wdata_o, bank_wmask_o);
    end
    tick();
    drive(0, '0, '0, '0, 1, 4'd3);
    n_checks++;
    if (rd_ready_o !== 1'b1 || rd_rsp_valid_o !== 1'b0 || bank_we_o !== 1'b0) begin
      n_fail++; $display("FAIL mw_read_gnt rdy=%b rsp=%b we=%b want 1 0 0", rd_ready_o, rd_rsp_valid_o, bank_we_o);
    end
    tick();
    drive(0, '0, '0, '0, 0, '0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== 32'hFFFF_5678) begin
      n_fail++; $display("FAIL mw_rsp valid=%b data=%h want 1 ffff5678", rd_rsp_valid_o, rd_rsp_data_o);
    end
    tick();
    drive(0, '0, '0, '0, 0, '0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b0 || bank_cs_o !== 1'b0 || bank_addr_o !== '0 || bank_wmask_o !== '0) begin
      n_fail++; $display("FAIL mw_idle rsp=%b cs=%b addr=%0d wmask=%h want 0 0 0 0",
                         rd_rsp_valid_o, bank_cs_o, bank_addr_o, bank_wmask_o);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] want_rd;
    want_rd = 4'b0101;  // cycle k bit k: READ, WRITE, READ, WRITE
    do_reset();
    idle_sweep();
    for (int k = 0; k < 4; k++) begin
      drive(1, AW'($urandom), $urandom, $urandom, 1, AW'($urandom));
      n_checks++;
      if (rd_ready_o !== want_rd[k] || wr_ready_o !== !want_rd[k]) begin
        n_fail++; $display("FAIL contention_cycle%0d rd_ready=%b wr_ready=%b want %b %b",
                           k, rd_ready_o, wr_ready_o, want_rd[k], !want_rd[k]);
      end
      tick();
    end
    drive(0, '0, '0, '0, 0, '0);
    tick();
  endtask

  task automatic test_stream_reads();
    for (int i = 0; i < 8; i++) begin
      drive(1, AW'(i), DW'(i * 3), 32'hFFFF_FFFF, 0, '0);
      tick();
    end
    for (int i = 0; i <= 8; i++) begin
      drive(0, '0, '0, '0, i < 8, AW'(i));
      n_checks++;
      if (rd_ready_o !== (i < 8)) begin
        n_fail++; $display("FAIL stream_gnt%0d rd_ready=%b want %b", i, rd_ready_o, i < 8);
      end
      if (i > 0) begin
        n_checks++;
        if (rd_rsp_valid_o !== 1'b1 || rd_rsp_data_o !== DW'((i - 1) * 3)) begin
          n_fail++; $display("FAIL stream_rsp%0d valid=%b data=%0d want 1 %0d",
                             i - 1, rd_rsp_valid_o, rd_rsp_data_o, (i - 1) * 3);
        end
      end
      tick();
    end
    drive(0, '0, '0, '0, 0, '0);
    n_checks++;
    if (rd_rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stream_tail rsp_valid=%b want 0", rd_rsp_valid_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_traffic();
    drive(0, '0, '0, '0, 1, 4'd2);
    n_checks++;
    if (rd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL midtraffic_gnt rd_ready=%b want 1", rd_ready_o);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rd_rsp_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL midtraffic_pend rsp_valid=%b want 1", rd_rsp_valid_o);
    end
    rst = 1'b1;
    rd_valid_i = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rd_rsp_valid_o !== 1'b0 || busy_o !== INIT_EN) begin
      n_fail++; $display("FAIL midtraffic_drop rsp_valid=%b busy=%b want 0 %b", rd_rsp_valid_o, busy_o, INIT_EN);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_sweep();
  endtask

  task automatic test_random();
    bit wv, rv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      wv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 3) != 0);
      drive(wv, AW'($urandom), $urandom, $urandom, rv, AW'($urandom));
      n_checks++;
      if ({wr_ready_o, rd_ready_o, busy_o, rd_rsp_valid_o} !== {e_wr, e_rd, e_busy, e_rsp_v}) begin
        n_fail++; $display("FAIL rand%0d wrdy/rrdy/busy/rspv=%b want %b", c,
                           {wr_ready_o, rd_ready_o, busy_o, rd_rsp_valid_o}, {e_wr, e_rd, e_busy, e_rsp_v});
      end
      n_checks++;
      if ({bank_cs_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_wmask_o}
          !== {e_cs, e_we, e_addr, e_wdata, e_wmask}) begin
        n_fail++; $display("FAIL rand%0d_bank cs/we/addr/wdata/wmask=%b/%b/%0d/%h/%h want %b/%b/%0d/%h/%h", c,
                           bank_cs_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_wmask_o,
                           e_cs, e_we, e_addr, e_wdata, e_wmask);
      end
      if (e_rsp_v) begin
        n_checks++;
        if (rd_rsp_data_o !== e_rsp_d) begin
          n_fail++; $display("FAIL rand%0d_rdata got=%h want %h", c, rd_rsp_data_o, e_rsp_d);
        end
      end
      tick();
    end
    drive(0, '0, '0, '0, 0, '0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    wr_valid_i = 0; wr_addr_i = '0; wr_data_i = '0; wr_mask_i = '0;
    rd_valid_i = 0; rd_addr_i = '0;
    seed = $urandom;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = init_pat(i, seed);
    end
    model_reset();

    test_reset();
`ifdef HPDCACHE_REGBANK_ARB_INIT_EN
    test_init_sweep();
`else
    test_macro_off();
`endif
    test_masked_write();
    test_contention();
    test_stream_reads();
    test_reset_mid_traffic();
`ifdef HPDCACHE_REGBANK_ARB_INIT_EN
    test_reset_mid_init();
`endif
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
